// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Operands in and the result out each use a valid/ready handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;

  // One full-subtractor cell working on the current LSBs
  logic             cell_x, cell_y, cell_d, cell_b;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    cell_x    = sa_q[0];
    cell_y    = sb_q[0];
    cell_d    = cell_x ^ cell_y ^ br_q;
    cell_b    = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & br_q);
    res_shift = {cell_d, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d      = state_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    res_d        = res_q;
    br_d         = br_q;
    cnt_d        = cnt_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sa_d       = a;
          sb_d       = b;
          br_d       = borrow_in;
          res_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        res_d = res_shift;
        br_d  = cell_b;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        // Last bit: publish the completed result together with out_valid
        if (cnt_q == LAST_BIT) begin
          diff_d       = res_shift;
          borrow_out_d = cell_b;
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sa_q         <= '0;
      sb_q         <= '0;
      res_q        <= '0;
      br_q         <= 1'b0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      res_q        <= res_d;
      br_q         <= br_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 and WIDTH=32 instances checked every cycle
// against a cycle-count/arithmetic model, plus directed literal cases on WIDTH=8.
module tb_serial_subtractor;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  logic       in_valid8 = 1'b0, out_ready8 = 1'b1, borrow_in8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_ready8, out_valid8, borrow_out8;
  logic [7:0] diff8;

  logic        in_valid32 = 1'b0, out_ready32 = 1'b1, borrow_in32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        in_ready32, out_valid32, borrow_out32;
  logic [31:0] diff32;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8), .borrow_in(borrow_in8),
    .out_valid(out_valid8), .out_ready(out_ready8), .diff(diff8), .borrow_out(borrow_out8)
  );

  serial_subtractor #(.WIDTH(32)) dut32 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .b(b32), .borrow_in(borrow_in32),
    .out_valid(out_valid32), .out_ready(out_ready32), .diff(diff32), .borrow_out(borrow_out32)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic reference: {borrow, diff mod 2^w}
  function automatic logic [32:0] ref_sub(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic bin);
    longint t, mask;
    t    = longint'(x) - longint'(y) - longint'(bin);
    mask = (longint'(1) << w) - 1;
    return {(t < 0), 32'(t & mask)};
  endfunction

  // Uniform views of both DUTs, index 0 = WIDTH 8, index 1 = WIDTH 32
  int          wv[2] = '{8, 32};
  logic        v_iv[2], v_bin[2], v_or[2], v_ir[2], v_ov[2], v_bo[2];
  logic [31:0] v_a[2], v_b[2], v_diff[2];

  assign v_iv[0] = in_valid8;   assign v_iv[1] = in_valid32;
  assign v_bin[0] = borrow_in8; assign v_bin[1] = borrow_in32;
  assign v_or[0] = out_ready8;  assign v_or[1] = out_ready32;
  assign v_ir[0] = in_ready8;   assign v_ir[1] = in_ready32;
  assign v_ov[0] = out_valid8;  assign v_ov[1] = out_valid32;
  assign v_bo[0] = borrow_out8; assign v_bo[1] = borrow_out32;
  assign v_a[0] = 32'(a8);      assign v_a[1] = a32;
  assign v_b[0] = 32'(b8);      assign v_b[1] = b32;
  assign v_diff[0] = 32'(diff8); assign v_diff[1] = diff32;

  // Timeline model: busy for WIDTH cycles after accept, then result until taken
  logic        m_busy[2], m_ov[2], m_bo[2], p_bo[2];
  int          m_cnt[2], acc[2], done[2], hs[2];
  logic [31:0] m_diff[2], p_diff[2];

  always @(posedge clock or negedge reset_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_busy[k] = 1'b0; m_ov[k] = 1'b0; m_cnt[k] = 0;
        m_diff[k] = '0;   m_bo[k] = 1'b0;
        acc[k] = 0; done[k] = 0; hs[k] = 0;
      end else begin
        if (v_ov[k] && v_or[k]) hs[k]++;
        if (!m_busy[k]) begin
          if (v_iv[k]) begin
            {p_bo[k], p_diff[k]} = ref_sub(wv[k], v_a[k], v_b[k], v_bin[k]);
            m_busy[k] = 1'b1;
            m_cnt[k]  = 0;
            acc[k]++;
          end
        end else if (!m_ov[k]) begin
          m_cnt[k]++;
          if (m_cnt[k] == wv[k]) begin
            m_ov[k]   = 1'b1;
            m_diff[k] = p_diff[k];
            m_bo[k]   = p_bo[k];
          end
        end else if (v_or[k]) begin
          m_ov[k]   = 1'b0;
          m_busy[k] = 1'b0;
          done[k]++;
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("in_ready w%0d", wv[k]), 33'(v_ir[k]), 33'(!m_busy[k]));
      check($sformatf("out_valid w%0d", wv[k]), 33'(v_ov[k]), 33'(m_ov[k]));
      check($sformatf("diff w%0d", wv[k]), 33'(v_diff[k]), 33'(m_diff[k]));
      check($sformatf("borrow_out w%0d", wv[k]), 33'(v_bo[k]), 33'(m_bo[k]));
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Directed op on the 8-bit instance with literal expectations
  task automatic op8(input logic [7:0] xa, input logic [7:0] xb, input logic bin,
                     input int stall, input bit noise,
                     input logic [7:0] ed, input logic eb);
    in_valid8 = 1'b1; a8 = xa; b8 = xb; borrow_in8 = bin;
    out_ready8 = (stall == 0);
    tick;
    check("op8 in_ready after accept", 33'(in_ready8), 33'(0));
    for (int i = 1; i < 8; i++) begin
      if (noise) begin
        in_valid8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); borrow_in8 = 1'($urandom);
      end else begin
        in_valid8 = 1'b0;
      end
      tick;
      check("op8 out_valid during shift", 33'(out_valid8), 33'(0));
    end
    tick;
    check("op8 out_valid at latency", 33'(out_valid8), 33'(1));
    check("op8 diff", 33'(diff8), 33'(ed));
    check("op8 borrow_out", 33'(borrow_out8), 33'(eb));
    for (int i = 0; i < stall; i++) begin
      if (noise) begin
        in_valid8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      end
      tick;
      check("op8 held diff", 33'(diff8), 33'(ed));
      check("op8 held borrow", 33'(borrow_out8), 33'(eb));
      check("op8 held out_valid", 33'(out_valid8), 33'(1));
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    tick;
    check("op8 out_valid after take", 33'(out_valid8), 33'(0));
    check("op8 in_ready after take", 33'(in_ready8), 33'(1));
    check("op8 diff retained", 33'(diff8), 33'(ed));
  endtask

  task automatic rand_stream(input int k);
    int cyc = 0;
    while (acc[k] < 1000 && cyc < 60000) begin
      if (k == 0) begin
        in_valid8 = ($urandom_range(3) != 0); a8 = 8'($urandom); b8 = 8'($urandom);
        borrow_in8 = 1'($urandom); out_ready8 = ($urandom_range(3) != 0);
      end else begin
        in_valid32 = ($urandom_range(3) != 0); a32 = $urandom; b32 = $urandom;
        borrow_in32 = 1'($urandom); out_ready32 = ($urandom_range(3) != 0);
      end
      tick;
      cyc++;
    end
    if (k == 0) begin in_valid8 = 1'b0; out_ready8 = 1'b1; end
    else begin in_valid32 = 1'b0; out_ready32 = 1'b1; end
    check($sformatf("stream w%0d accepted", wv[k]), 33'(acc[k]), 33'(1000));
    cyc = 0;
    while (done[k] < acc[k] && cyc < 200) begin
      tick;
      cyc++;
    end
    check($sformatf("stream w%0d delivered", wv[k]), 33'(hs[k]), 33'(1000));
    check($sformatf("stream w%0d drained", wv[k]), 33'(done[k]), 33'(acc[k]));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset_n = 1'b0;
    #1;
    check("reset in_ready", 33'(in_ready8), 33'(1));
    check("reset out_valid", 33'(out_valid8), 33'(0));
    check("reset diff", 33'(diff8), 33'(0));
    check("reset borrow_out", 33'(borrow_out8), 33'(0));
    repeat (2) tick;
    reset_n = 1'b1;
    repeat (3) tick;
    check("idle in_ready", 33'(in_ready8), 33'(1));
    check("idle out_valid", 33'(out_valid8), 33'(0));

    op8(8'h5A, 8'h21, 1'b0, 0, 1'b0, 8'h39, 1'b0);
    op8(8'h03, 8'h05, 1'b1, 0, 1'b0, 8'hFD, 1'b1);
    op8(8'h00, 8'h00, 1'b1, 0, 1'b0, 8'hFF, 1'b1);
    op8(8'h80, 8'h01, 1'b0, 5, 1'b1, 8'h7F, 1'b0);

    // Abort mid-shift with a reset pulse between clock edges
    in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h0F; borrow_in8 = 1'b0;
    tick;
    in_valid8 = 1'b0;
    repeat (3) tick;
    #2 reset_n = 1'b0;
    #1;
    check("midop reset in_ready", 33'(in_ready8), 33'(1));
    check("midop reset out_valid", 33'(out_valid8), 33'(0));
    check("midop reset diff", 33'(diff8), 33'(0));
    check("midop reset borrow_out", 33'(borrow_out8), 33'(0));
    #3 reset_n = 1'b1;
    repeat (12) begin
      tick;
      check("after abort out_valid", 33'(out_valid8), 33'(0));
    end
    op8(8'h10, 8'h01, 1'b0, 0, 1'b0, 8'h0F, 1'b0);

    // Fresh counters for the random streams
    tick;
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    fork
      rand_stream(0);
      rand_stream(1);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
